// File: rtl/phase_acc_serial_pkg.sv
// phase_pkg: shared sizes and FSM encoding for the digit-serial accumulate phase.
package phase_pkg;
    localparam int SIZE = 3072;
    localparam int RADIX = 72;
    localparam int SIZE_LOG = 6;
    localparam int LIMB = 128;
    localparam int NLIMB = SIZE / LIMB;
    localparam int W = SIZE + RADIX + SIZE_LOG;
    localparam int CW = RADIX + 1;
    localparam int HW = RADIX + SIZE_LOG;
    localparam int UW = HW + 1;
    localparam int KW = $clog2(NLIMB);
    typedef enum logic [1:0] {IDLE, MAC, TAIL, DONE} state_t;
endpackage

// File: rtl/phase_acc_serial_limb_mac.sv
// limb_mac: one LIMB x RADIX multiply-accumulate step with carry in/out.
module limb_mac
    import phase_pkg::*;
(
    input  logic [LIMB-1:0]  a,
    input  logic [RADIX-1:0] b,
    input  logic [LIMB-1:0]  c,
    input  logic [CW-1:0]    cin,
    output logic [LIMB-1:0]  s,
    output logic [CW-1:0]    cout
);
    localparam int TW = LIMB + CW;
    logic [TW-1:0] t;
    assign t = TW'(a) * TW'(b) + TW'(c) + TW'(cin);
    assign s = t[LIMB-1:0];
    assign cout = t[TW-1:LIMB];
endmodule

// File: rtl/phase_acc_serial.sv
// phase_acc_serial: new_c = c + a*bi (optionally >> RADIX), one LIMB slice of a per cycle.
module phase_acc_serial
    import phase_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     c,
    input  logic [SIZE-1:0]  a,
    input  logic [RADIX-1:0] bi,
    input  logic             mode_shift,
    output logic             ready,
    output logic             busy,
    output logic [W-1:0]     new_c,
    output logic             en_out,
    output logic             ovf,
    output logic             drop
);
    state_t state, state_n;
    logic [SIZE-1:0] a_r, c_lo, sum_r;
    logic [HW-1:0] c_hi;
    logic [RADIX-1:0] bi_r;
    logic ms;
    logic [KW-1:0] k;
    logic [CW-1:0] carry, carry_n;
    logic [LIMB-1:0] s;
    logic [UW-1:0] u;
    logic [W-1:0] sum_full, res;
    logic start;

    assign ready = state == IDLE || state == DONE;
    assign busy = state == MAC || state == TAIL || (state == DONE && !en_out);
    assign start = en && ready;

    limb_mac u_mac (
        .a(a_r[LIMB-1:0]),
        .b(bi_r),
        .c(c_lo[LIMB-1:0]),
        .cin(carry),
        .s(s),
        .cout(carry_n)
    );

    always_comb begin
        u = {1'b0, c_hi} + UW'(carry);
        sum_full = {u[HW-1:0], sum_r};
        res = ms ? sum_full >> RADIX : sum_full;
        state_n = ready ? (en ? MAC : IDLE)
                : state == MAC ? (k == KW'(NLIMB - 1) ? TAIL : MAC)
                : DONE;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Operands shift down one limb per cycle; finished sum limbs enter from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            c_lo <= '0;
            c_hi <= '0;
            sum_r <= '0;
            bi_r <= '0;
            ms <= 1'b0;
            k <= '0;
            carry <= '0;
            new_c <= '0;
            en_out <= 1'b0;
            ovf <= 1'b0;
            drop <= 1'b0;
        end else begin
            drop <= en && !ready;
            en_out <= state == TAIL;
            if (start) begin
                a_r <= a;
                c_lo <= c[SIZE-1:0];
                c_hi <= c[W-1:SIZE];
                bi_r <= bi;
                ms <= mode_shift;
                k <= '0;
                carry <= '0;
            end else if (state == MAC) begin
                a_r <= a_r >> LIMB;
                c_lo <= c_lo >> LIMB;
                sum_r <= {s, sum_r[SIZE-1:LIMB]};
                carry <= carry_n;
                k <= k + KW'(1);
            end
            if (state == TAIL) begin
                new_c <= res;
                ovf <= u[UW-1];
            end
        end
    end
endmodule

// File: tb/tb_phase_acc_serial.sv
// tb_phase_acc_serial: directed vectors and handshake corner cases for phase_acc_serial.
module tb_phase_acc_serial;
    import phase_pkg::*;

    typedef struct {
        logic [W-1:0]     c;
        logic [SIZE-1:0]  a;
        logic [RADIX-1:0] bi;
        logic             ms;
        logic [W-1:0]     exp_c;
        logic             exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst, en, mode_shift;
    logic [W-1:0] c, new_c;
    logic [SIZE-1:0] a;
    logic [RADIX-1:0] bi;
    logic ready, busy, en_out, ovf, drop;
    int tests = 0;
    int fails = 0;
    vec_t v[9];

    always #5 clk = ~clk;

    phase_acc_serial dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .c(c),
        .a(a),
        .bi(bi),
        .mode_shift(mode_shift),
        .ready(ready),
        .busy(busy),
        .new_c(new_c),
        .en_out(en_out),
        .ovf(ovf),
        .drop(drop)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chkn(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got low64 %h expected low64 %h (%0d bits differ)",
                     name, got[63:0], exp[63:0], $countones(got ^ exp));
        end
    endtask

    // Inputs are inverted right after capture so a design that re-reads them is caught.
    task automatic launch(input logic [W-1:0] cv, input logic [SIZE-1:0] av,
                          input logic [RADIX-1:0] bv, input logic mv);
        c = cv;
        a = av;
        bi = bv;
        mode_shift = mv;
        en = 1'b1;
        step;
        en = 1'b0;
        c = ~cv;
        a = ~av;
        bi = ~bv;
        mode_shift = ~mv;
    endtask

    task automatic wait_done(input int from, output int cyc, output logic busy_ok);
        cyc = from;
        busy_ok = 1'b1;
        while (!en_out && cyc < 200) begin
            if (!busy || ready) busy_ok = 1'b0;
            step;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic ok;
        v[0] = '{W'(0), SIZE'(1), RADIX'(1), 1'b0, W'(1), 1'b0};
        v[1] = '{W'(0), SIZE'(1) << 3071, RADIX'(1) << 71, 1'b1, W'(1) << 3070, 1'b0};
        v[2] = '{W'(0), SIZE'(1) << 3071, RADIX'(1) << 71, 1'b0, W'(1) << 3142, 1'b0};
        v[3] = '{'1, SIZE'(1), RADIX'(1), 1'b0, W'(0), 1'b1};
        v[4] = '{(W'(1) << SIZE) - W'(1), SIZE'(1), RADIX'(1), 1'b0, W'(1) << 3072, 1'b0};
        v[5] = '{W'(7), SIZE'(3), RADIX'(5), 1'b0, W'(22), 1'b0};
        v[6] = '{W'(0), '1, '1, 1'b0,
                 (W'(1) << 3144) - (W'(1) << 3072) - (W'(1) << 72) + W'(1), 1'b0};
        v[7] = '{W'(1) << 3149, SIZE'(1) << 3071, RADIX'(1) << 71, 1'b1,
                 (W'(1) << 3077) | (W'(1) << 3070), 1'b0};
        v[8] = '{'1, SIZE'(1), RADIX'(1), 1'b1, W'(0), 1'b1};

        rst = 1'b1;
        en = 1'b0;
        c = '0;
        a = '0;
        bi = '0;
        mode_shift = 1'b0;
        step;
        step;
        rst = 1'b0;
        chkw("reset new_c", new_c, '0);
        chk1("reset en_out", en_out, 1'b0);
        chk1("reset ovf", ovf, 1'b0);
        chk1("reset drop", drop, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset ready", ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            launch(v[i].c, v[i].a, v[i].bi, v[i].ms);
            wait_done(1, cyc, ok);
            chkn($sformatf("vec%0d latency", i), cyc, 26);
            chk1($sformatf("vec%0d busy/ready in flight", i), ok, 1'b1);
            chkw($sformatf("vec%0d new_c", i), new_c, v[i].exp_c);
            chk1($sformatf("vec%0d ovf", i), ovf, v[i].exp_ovf);
            step;
            chkw($sformatf("vec%0d new_c held", i), new_c, v[i].exp_c);
        end

        // Back-to-back: next start issued in the DONE cycle.
        launch(W'(0), SIZE'(1), RADIX'(1), 1'b0);
        wait_done(1, cyc, ok);
        chk1("b2b ready in done", ready, 1'b1);
        chk1("b2b busy in done", busy, 1'b0);
        launch(W'(7), SIZE'(3), RADIX'(5), 1'b0);
        chk1("b2b drop", drop, 1'b0);
        chk1("b2b busy", busy, 1'b1);
        chkw("b2b first result held", new_c, W'(1));
        wait_done(1, cyc, ok);
        chkn("b2b latency", cyc, 26);
        chkw("b2b new_c", new_c, W'(22));
        step;

        // Start while busy is dropped and reported.
        launch(W'(7), SIZE'(3), RADIX'(5), 1'b0);
        repeat (4) step;
        c = '0;
        a = SIZE'(9);
        bi = RADIX'(9);
        en = 1'b1;
        step;
        en = 1'b0;
        chk1("busy start drop pulse", drop, 1'b1);
        step;
        chk1("busy start drop cleared", drop, 1'b0);
        wait_done(7, cyc, ok);
        chkn("busy start latency", cyc, 26);
        chk1("busy start busy/ready", ok, 1'b1);
        chkw("busy start new_c", new_c, W'(22));
        step;

        // Reset mid-operation aborts it.
        launch(W'(0), SIZE'(1), RADIX'(1), 1'b0);
        repeat (9) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst ready", ready, 1'b1);
        chk1("midrst en_out", en_out, 1'b0);
        chkw("midrst new_c", new_c, '0);
        step;
        launch(W'(7), SIZE'(3), RADIX'(5), 1'b0);
        wait_done(1, cyc, ok);
        chkn("midrst restart latency", cyc, 26);
        chkw("midrst restart new_c", new_c, W'(22));
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
